sine_pwm_dac: RTL

Downstream output stage for the sine generator. It consumes the 4-bit offset-binary SINE samples, one per frame, and converts each into a 1-bit pulse stream for an off-chip RC filter. Two modulation modes are supported: frame-aligned PWM and first-order sigma-delta. It emits a per-frame STEP strobe, which upstream logic uses as its advance enable, and it flags any sample underrun.

---
 rtl/sine_pwm_dac_if.sv | 30 +++
 rtl/sine_pwm_dac.sv | 120 ++++++++++++
 2 files changed

// File: rtl/sine_pwm_dac_if.sv
// -----------------------------------------------------------------------------
// sine_pwm_dac_if
//   Sample hand-off between the sine generator (master) and the PWM /
//   sigma-delta output stage (slave).
//
//   sample       : offset-binary sample, master -> slave
//   sample_valid : sample is valid this cycle, master -> slave
//   step         : high in the last cycle of each frame; the slave accepts
//                  the sample on the edge that ends this cycle, and the master
//                  uses it as its advance enable. slave -> master
// -----------------------------------------------------------------------------
interface sine_pwm_dac_if #(
    parameter int DATA_W = 4
);
    logic [DATA_W-1:0] sample;
    logic              sample_valid;
    logic              step;

    modport master (
        output sample,
        output sample_valid,
        input  step
    );

    modport slave (
        input  sample,
        input  sample_valid,
        output step
    );
endinterface

// File: rtl/sine_pwm_dac.sv
// -----------------------------------------------------------------------------
// sine_pwm_dac
//   Converts one offset-binary sample per frame into a 1-bit pulse stream for
//   an external RC filter. A frame is 2^FRAME_W clocks. Two modulators:
//     PWM         : DUTY contiguous ones per frame, frame aligned.
//     sigma-delta : first-order accumulator, carry-out is the output bit.
//   The sample and the mode are only taken at frame boundaries, so the output
//   is never disturbed mid-frame.
//
// Ports
//   i_clk          : system clock, rising edge
//   i_rst_n        : synchronous reset, active low
//   i_enable       : run enable; low parks counter/accumulator and output at 0
//   i_mode         : 0 = PWM, 1 = sigma-delta (sampled at frame boundary)
//   i_clr_underrun : clears the sticky underrun flag
//   bus            : slave side of the sample hand-off (sample, valid, step)
//   o_dac_out      : modulated bit stream (registered)
//   o_cur_sample   : sample currently being modulated
//   o_underrun     : sticky; a frame boundary passed without a valid sample
// -----------------------------------------------------------------------------
module sine_pwm_dac #(
    parameter int DATA_W  = 4,
    parameter int FRAME_W = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_enable,
    input  logic                 i_mode,
    input  logic                 i_clr_underrun,
    sine_pwm_dac_if.slave        bus,
    output logic                 o_dac_out,
    output logic [DATA_W-1:0]    o_cur_sample,
    output logic                 o_underrun
);

    // The duty scaling below left-shifts the sample into the frame range,
    // which only works when the frame is at least as wide as the sample.
    generate
        if (FRAME_W < DATA_W) begin : g_bad_cfg
            $error("sine_pwm_dac: FRAME_W must be >= DATA_W");
        end
    endgenerate

    localparam logic [DATA_W-1:0]  MIDSCALE = DATA_W'(1) << (DATA_W - 1);
    localparam logic [FRAME_W-1:0] CNT_LAST = {FRAME_W{1'b1}};
    localparam logic               MODE_PWM = 1'b0;

    logic [FRAME_W-1:0] r_cnt;
    logic [FRAME_W-1:0] r_acc;
    logic [DATA_W-1:0]  r_cur_sample;
    logic               r_mode;
    logic               r_dac;
    logic               r_underrun;

    logic               w_step;
    logic [FRAME_W-1:0] w_duty;
    logic [FRAME_W:0]   w_sd_sum;
    logic               w_pwm_bit;

    // Last cycle of the frame; gated by enable so a disable landing on the
    // boundary cycle skips the capture entirely.
    assign w_step    = i_enable && (r_cnt == CNT_LAST);

    assign w_duty    = FRAME_W'(r_cur_sample) << (FRAME_W - DATA_W);
    assign w_pwm_bit = (r_cnt < w_duty);

    // One extra bit so the top bit is the carry that drives the output.
    assign w_sd_sum  = {1'b0, r_acc} + {1'b0, w_duty};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt        <= '0;
            r_acc        <= '0;
            r_cur_sample <= MIDSCALE;
            r_mode       <= MODE_PWM;
            r_dac        <= 1'b0;
            r_underrun   <= 1'b0;
        end else if (!i_enable) begin
            // Sample, mode and underrun survive a disable; the frame restarts.
            r_cnt <= '0;
            r_acc <= '0;
            r_dac <= 1'b0;
        end else begin
            r_cnt <= r_cnt + FRAME_W'(1);

            // Modulator runs on the mode/sample that were active this cycle;
            // the boundary capture below only affects the next frame.
            if (r_mode == MODE_PWM) begin
                r_dac <= w_pwm_bit;
            end else begin
                r_dac <= w_sd_sum[FRAME_W];
                r_acc <= w_sd_sum[FRAME_W-1:0];
            end

            if (w_step) begin
                if (bus.sample_valid) begin
                    r_cur_sample <= bus.sample;
                end
                r_mode <= i_mode;
                // A fresh modulator starts from a clean accumulator.
                if (i_mode != r_mode) begin
                    r_acc <= '0;
                end
            end

            // Set wins over clear when both land on the same edge.
            if (w_step && !bus.sample_valid) begin
                r_underrun <= 1'b1;
            end else if (i_clr_underrun) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign bus.step     = w_step;
    assign o_dac_out    = r_dac;
    assign o_cur_sample = r_cur_sample;
    assign o_underrun   = r_underrun;

endmodule
